adc_spi_responder: RTL

//  SPI peripheral (responder) that answers the sonar SPI controller exactly as the external ADC does.

---
 rtl/sonic_pkg.sv | 15 +
 rtl/sample_fifo.sv | 55 +++++
 rtl/adc_spi_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sonic_pkg.sv
// Shared constants and types for the sonar receive-chain bring-up blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ADC_DATA_WIDTH (ADC sample / SPI frame width), spi_resp_state_t (responder FSM states).
package sonic_pkg;

   localparam int ADC_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_resp_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO holding samples queued for the SPI responder.
// Latency: a pushed word is visible at head_dat on the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop same cycle both honoured.
// Ports:
//   clk_in, rst_n       clock, asynchronous active-low reset (pointers only)
//   push, push_dat      write request and data
//   pop                 read request; head_dat is the current head (valid when !empty)
//   full, empty, count  occupancy status
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_in) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder (CPOL=0, CPHA=0, MSB first) that mimics the external ADC, serving one queued sample per frame.
// Latency: SYNC_STAGES+1 clk_in cycles from any chip_sel_in/chip_clk_in edge to the resulting chip_data_out change.
// Backpressure: sample_ready_out = FIFO not full; empty FIFO at frame start replays the last sample and flags underrun.
// Ports:
//   clk_in, rst_n                               system clock, asynchronous active-low reset
//   sample_in, sample_valid_in, sample_ready_out sample push interface (valid/ready)
//   chip_clk_in, chip_sel_in, chip_data_out     SPI dclk, cs (active low), cipo
//   busy_out                                    frame in progress (SHIFT or DONE)
//   frame_done_out, frame_abort_out, underrun_out  single-cycle event pulses
module adc_spi_responder
   import sonic_pkg::*;
#(
   parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 0
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid_in,
   output logic                  sample_ready_out,
   input  logic                  chip_clk_in,
   input  logic                  chip_sel_in,
   output logic                  chip_data_out,
   output logic                  busy_out,
   output logic                  frame_done_out,
   output logic                  frame_abort_out,
   output logic                  underrun_out
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   // ------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ------------------------------------------------------------------
   logic chip_clk_s;
   logic chip_sel_s;

   generate
      if (SYNC_STAGES == 0) begin : g_no_sync
         assign chip_clk_s = chip_clk_in;
         assign chip_sel_s = chip_sel_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] clk_pipe;
         logic [SYNC_STAGES-1:0] sel_pipe;

         // cs resets to its idle (high) level so reset release cannot fake a cs_fall.
         always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
               clk_pipe <= '0;
               sel_pipe <= '1;
            end else begin
               clk_pipe[0] <= chip_clk_in;
               sel_pipe[0] <= chip_sel_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  clk_pipe[i] <= clk_pipe[i-1];
                  sel_pipe[i] <= sel_pipe[i-1];
               end
            end
         end

         assign chip_clk_s = clk_pipe[SYNC_STAGES-1];
         assign chip_sel_s = sel_pipe[SYNC_STAGES-1];
      end
   endgenerate

   logic chip_clk_h;
   logic chip_sel_h;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         chip_clk_h <= 1'b0;
         chip_sel_h <= 1'b1;
      end else begin
         chip_clk_h <= chip_clk_s;
         chip_sel_h <= chip_sel_s;
      end
   end

   logic clk_rise;
   logic clk_fall;
   logic cs_rise;
   logic cs_fall;

   assign clk_rise =  chip_clk_s && !chip_clk_h;
   assign clk_fall = !chip_clk_s &&  chip_clk_h;
   assign cs_rise  =  chip_sel_s && !chip_sel_h;
   assign cs_fall  = !chip_sel_s &&  chip_sel_h;

   // ------------------------------------------------------------------
   // Sample FIFO
   // ------------------------------------------------------------------
   spi_resp_state_t           state;
   logic [DATA_WIDTH-1:0]     fifo_head;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_pop;
   logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

   assign sample_ready_out = !fifo_full;
   assign fifo_pop         = (state == IDLE) && cs_fall && !fifo_empty;

   sample_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .push     (sample_valid_in),
      .push_dat (sample_in),
      .pop      (fifo_pop),
      .head_dat (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (unused_fifo_count)
   );

   // ------------------------------------------------------------------
   // Frame FSM, bit counter and shift register
   // ------------------------------------------------------------------
   logic [CW-1:0]         bit_cnt;
   logic [CW-1:0]         cnt_next;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] last_sample;
   logic [DATA_WIDTH-1:0] load_val;

   // clk_rise is counted before cs_rise is considered, so a frame whose last
   // rising edge coincides with cs_rise still completes.
   assign cnt_next = bit_cnt + CW'(clk_rise);
   assign load_val = fifo_empty ? last_sample : fifo_head;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         bit_cnt         <= '0;
         shift_reg       <= '0;
         last_sample     <= '0;
         chip_data_out   <= 1'b0;
         busy_out        <= 1'b0;
         frame_done_out  <= 1'b0;
         frame_abort_out <= 1'b0;
         underrun_out    <= 1'b0;
      end else begin
         frame_done_out  <= 1'b0;
         frame_abort_out <= 1'b0;
         underrun_out    <= 1'b0;

         case (state)
            IDLE: begin
               chip_data_out <= 1'b0;
               busy_out      <= 1'b0;
               if (cs_fall) begin
                  // CPHA=0: the MSB must be on the wire before the first rising edge.
                  shift_reg     <= load_val;
                  chip_data_out <= load_val[DATA_WIDTH-1];
                  bit_cnt       <= '0;
                  busy_out      <= 1'b1;
                  state         <= SHIFT;
                  if (fifo_empty) underrun_out <= 1'b1;
                  else            last_sample  <= fifo_head;
               end
            end

            SHIFT: begin
               if (clk_rise && (cnt_next == CW'(DATA_WIDTH))) begin
                  bit_cnt        <= cnt_next;
                  chip_data_out  <= 1'b0;
                  frame_done_out <= 1'b1;
                  state          <= DONE;
               end else if (cs_rise) begin
                  // Popped sample is deliberately not restored.
                  chip_data_out   <= 1'b0;
                  busy_out        <= 1'b0;
                  frame_abort_out <= 1'b1;
                  state           <= IDLE;
               end else begin
                  bit_cnt <= cnt_next;
                  // A falling edge before any rising edge (dclk high at cs_fall)
                  // must not advance: the MSB has not been sampled yet.
                  if (clk_fall && (bit_cnt != '0)) begin
                     // Rotate rather than shift; bits past the frame are never driven.
                     shift_reg     <= {shift_reg[DATA_WIDTH-2:0], shift_reg[DATA_WIDTH-1]};
                     chip_data_out <= shift_reg[DATA_WIDTH-2];
                  end
               end
            end

            DONE: begin
               chip_data_out <= 1'b0;
               if (cs_rise) begin
                  busy_out <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: begin
               chip_data_out <= 1'b0;
               busy_out      <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule
